// File: rtl/pard_cp_pkg.sv
// Shared constants for the PARD control-plane register block:
// register addresses, TRIG_STAT field layout and register-select codes.
package pard_cp_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic [7:0] ADDR_DSID_BASE = 8'h00;
    localparam logic [7:0] ADDR_RST_PULSE = 8'h10;
    localparam logic [7:0] ADDR_RST_HOLD  = 8'h11;
    localparam logic [7:0] ADDR_TRIG_PUSH = 8'h12;
    localparam logic [7:0] ADDR_TRIG_STAT = 8'h13;
    localparam logic [7:0] ADDR_DSID_LOCK = 8'h14;

    localparam int unsigned STAT_LVL_LSB = 0;
    localparam int unsigned STAT_LVL_W   = 8;
    localparam int unsigned STAT_OVF_LSB = 16;
    localparam int unsigned STAT_OVF_W   = 16;

    typedef enum logic [2:0] {
        REG_BAD,
        REG_DSID,
        REG_RST_PULSE,
        REG_RST_HOLD,
        REG_TRIG_PUSH,
        REG_TRIG_STAT,
        REG_DSID_LOCK
    } reg_sel_e;

endpackage

// File: rtl/pard_cp_trig_fifo.sv
// Trigger word FIFO: drops pushes when full (unless a pop frees a slot in the
// same cycle), counts drops with a saturating counter, AXIS-style output.
module pard_cp_trig_fifo
    import pard_cp_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       stat_clr,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic [STAT_OVF_W-1:0]      ovf_cnt,
    output logic                       tvalid,
    input  logic                       tready,
    output logic [WIDTH-1:0]           tdata
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop;
    logic             accept;
    logic             drop;

    assign tvalid = (level != '0);
    assign tdata  = mem[rd_ptr];
    assign pop    = tvalid && tready;
    assign accept = push && ((level != FULL_LVL) || pop);
    assign drop   = push && !accept;

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            ovf_cnt <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            if (accept && !pop) begin
                level <= level + 1'b1;
            end else if (!accept && pop) begin
                level <= level - 1'b1;
            end
            // A drop coinciding with a clear leaves exactly that one drop counted.
            if (drop) begin
                if (stat_clr)            ovf_cnt <= STAT_OVF_W'(1);
                else if (ovf_cnt != '1)  ovf_cnt <= ovf_cnt + 1'b1;
            end else if (stat_clr) begin
                ovf_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/pard_core_ctrl_regs.sv
// Per-core control registers (DSID, ext-reset pulse/hold, trigger FIFO) behind
// a single-outstanding request/response port. PARD_CP_DSID_LOCK_EN adds DSID_LOCK.
module pard_core_ctrl_regs
    import pard_cp_pkg::*;
#(
    parameter int unsigned          NUM_CORES      = 3,
    parameter int unsigned          DSID_W         = 16,
    parameter int unsigned          TRIG_W         = 16,
    parameter int unsigned          TRIG_DEPTH     = 8,
    parameter int unsigned          RESET_CYCLES   = 16,
    parameter logic [NUM_CORES-1:0] HOLD_RESET_VAL = '1
) (
    input  logic                        SYS_CLK,
    input  logic                        RSTN,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_write,
    input  logic [7:0]                  req_addr,
    input  logic [DATA_W-1:0]           req_wdata,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [DATA_W-1:0]           resp_rdata,
    output logic                        resp_err,
    output logic [NUM_CORES-1:0]        ext_reset,
    output logic [NUM_CORES*DSID_W-1:0] dsid,
    output logic                        trigger_axis_tvalid,
    input  logic                        trigger_axis_tready,
    output logic [TRIG_W-1:0]           trigger_axis_tdata
);

    localparam int unsigned CNT_W = $clog2(RESET_CYCLES + 1);
    localparam int unsigned LVL_W = $clog2(TRIG_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RESET_CYCLES);
    localparam logic [4:0] NC5 = 5'(NUM_CORES);

    logic                  accept;
    reg_sel_e              sel;
    logic [3:0]            core_idx;
    logic [DSID_W-1:0]     dsid_r [NUM_CORES];
    logic [DSID_W-1:0]     dsid_cur;
    logic [NUM_CORES-1:0]  hold_r;
    logic [NUM_CORES-1:0]  hold_next;
    logic [NUM_CORES-1:0]  lock_r;
    logic                  lock_cur;
    logic [CNT_W-1:0]      cnt_r [NUM_CORES];
    logic [CNT_W-1:0]      cnt_next [NUM_CORES];
    logic [NUM_CORES-1:0]  ext_next;
    logic [DATA_W-1:0]     rd_data;
    logic                  rd_err;
    logic                  dsid_we, pulse_we, hold_we, trig_push, stat_clr;
    logic [LVL_W-1:0]      trig_level;
    logic [STAT_OVF_W-1:0] ovf_cnt;
    logic                  unused_wdata;

    assign req_ready    = !resp_valid;
    assign accept       = req_valid && req_ready;
    assign core_idx     = req_addr[3:0];
    assign unused_wdata = ^req_wdata;

    always_comb begin
        sel = REG_BAD;
        if (req_addr[7:4] == ADDR_DSID_BASE[7:4]) begin
            if ({1'b0, core_idx} < NC5) sel = REG_DSID;
        end else begin
            case (req_addr)
                ADDR_RST_PULSE: sel = REG_RST_PULSE;
                ADDR_RST_HOLD:  sel = REG_RST_HOLD;
                ADDR_TRIG_PUSH: sel = REG_TRIG_PUSH;
                ADDR_TRIG_STAT: sel = REG_TRIG_STAT;
`ifdef PARD_CP_DSID_LOCK_EN
                ADDR_DSID_LOCK: sel = REG_DSID_LOCK;
`endif
                default:        sel = REG_BAD;
            endcase
        end
    end

`ifdef PARD_CP_DSID_LOCK_EN
    logic lock_we;
`endif

    always_comb begin
        dsid_cur = '0;
        lock_cur = 1'b0;
        for (int unsigned c = 0; c < NUM_CORES; c++) begin
            if (core_idx == 4'(c)) begin
                dsid_cur = dsid_r[c];
                lock_cur = lock_r[c];
            end
        end
        rd_data   = '0;
        rd_err    = 1'b0;
        dsid_we   = 1'b0;
        pulse_we  = 1'b0;
        hold_we   = 1'b0;
        trig_push = 1'b0;
        stat_clr  = 1'b0;
`ifdef PARD_CP_DSID_LOCK_EN
        lock_we   = 1'b0;
`endif
        if (accept) begin
            case (sel)
                REG_DSID: begin
                    if (!req_write)    rd_data[DSID_W-1:0] = dsid_cur;
                    else if (lock_cur) rd_err = 1'b1;
                    else               dsid_we = 1'b1;
                end
                REG_RST_PULSE: begin
                    if (req_write) pulse_we = 1'b1;
                    else           rd_data[NUM_CORES-1:0] = ext_reset;
                end
                REG_RST_HOLD: begin
                    if (req_write) hold_we = 1'b1;
                    else           rd_data[NUM_CORES-1:0] = hold_r;
                end
                REG_TRIG_PUSH: begin
                    if (req_write) trig_push = 1'b1;
                    else           rd_err = 1'b1;
                end
                REG_TRIG_STAT: begin
                    if (req_write) begin
                        rd_err = 1'b1;
                    end else begin
                        rd_data[STAT_LVL_LSB +: STAT_LVL_W] = STAT_LVL_W'(trig_level);
                        rd_data[STAT_OVF_LSB +: STAT_OVF_W] = ovf_cnt;
                        stat_clr = 1'b1;
                    end
                end
`ifdef PARD_CP_DSID_LOCK_EN
                REG_DSID_LOCK: begin
                    if (req_write) lock_we = 1'b1;
                    else           rd_data[NUM_CORES-1:0] = lock_r;
                end
`endif
                default: rd_err = 1'b1;
            endcase
        end
    end

`ifdef PARD_CP_DSID_LOCK_EN
    always_ff @(posedge SYS_CLK or negedge RSTN) begin
        if (!RSTN)        lock_r <= '0;
        else if (lock_we) lock_r <= lock_r | req_wdata[NUM_CORES-1:0];
    end
`else
    assign lock_r = '0;
`endif

    always_ff @(posedge SYS_CLK or negedge RSTN) begin
        if (!RSTN) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else if (accept) begin
            resp_valid <= 1'b1;
            resp_rdata <= rd_data;
            resp_err   <= rd_err;
        end else if (resp_valid && resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

    always_ff @(posedge SYS_CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int unsigned c = 0; c < NUM_CORES; c++) dsid_r[c] <= '0;
        end else if (dsid_we) begin
            for (int unsigned c = 0; c < NUM_CORES; c++) begin
                if (core_idx == 4'(c)) dsid_r[c] <= req_wdata[DSID_W-1:0];
            end
        end
    end

    always_comb begin
        dsid = '0;
        for (int unsigned c = 0; c < NUM_CORES; c++) dsid[c*DSID_W +: DSID_W] = dsid_r[c];
    end

    // ext_reset registers the next-state view so a pulse or hold change shows
    // up the cycle after acceptance and a pulse lasts exactly RESET_CYCLES.
    always_comb begin
        hold_next = hold_we ? req_wdata[NUM_CORES-1:0] : hold_r;
        ext_next  = '0;
        for (int unsigned c = 0; c < NUM_CORES; c++) begin
            if (pulse_we && req_wdata[c]) cnt_next[c] = CNT_LOAD;
            else if (cnt_r[c] != '0)      cnt_next[c] = cnt_r[c] - 1'b1;
            else                          cnt_next[c] = '0;
            ext_next[c] = hold_next[c] | (cnt_next[c] != '0);
        end
    end

    always_ff @(posedge SYS_CLK or negedge RSTN) begin
        if (!RSTN) begin
            hold_r    <= HOLD_RESET_VAL;
            ext_reset <= HOLD_RESET_VAL;
            for (int unsigned c = 0; c < NUM_CORES; c++) cnt_r[c] <= '0;
        end else begin
            hold_r    <= hold_next;
            ext_reset <= ext_next;
            for (int unsigned c = 0; c < NUM_CORES; c++) cnt_r[c] <= cnt_next[c];
        end
    end

    pard_cp_trig_fifo #(
        .WIDTH (TRIG_W),
        .DEPTH (TRIG_DEPTH)
    ) u_trig_fifo (
        .clk       (SYS_CLK),
        .rst_n     (RSTN),
        .push      (trig_push),
        .push_data (req_wdata[TRIG_W-1:0]),
        .stat_clr  (stat_clr),
        .level     (trig_level),
        .ovf_cnt   (ovf_cnt),
        .tvalid    (trigger_axis_tvalid),
        .tready    (trigger_axis_tready),
        .tdata     (trigger_axis_tdata)
    );

endmodule

// File: tb/tb_pard_core_ctrl_regs.sv
// Bench for pard_core_ctrl_regs: directed scenarios then random traffic against
// a time-based reference model (pulse end times, word queue, drop counter).
module tb_pard_core_ctrl_regs;

    localparam int unsigned NC    = 3;
    localparam int unsigned DW    = 16;
    localparam int unsigned TW    = 16;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned RC    = 16;

    logic              SYS_CLK = 1'b0;
    logic              RSTN;
    logic              req_valid, req_ready, req_write;
    logic [7:0]        req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid, resp_ready, resp_err;
    logic [31:0]       resp_rdata;
    logic [NC-1:0]     ext_reset;
    logic [NC*DW-1:0]  dsid;
    logic              tvalid, tready;
    logic [TW-1:0]     tdata;

    pard_core_ctrl_regs #(
        .NUM_CORES      (NC),
        .DSID_W         (DW),
        .TRIG_W         (TW),
        .TRIG_DEPTH     (DEPTH),
        .RESET_CYCLES   (RC),
        .HOLD_RESET_VAL (3'b111)
    ) dut (
        .SYS_CLK             (SYS_CLK),
        .RSTN                (RSTN),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_write           (req_write),
        .req_addr            (req_addr),
        .req_wdata           (req_wdata),
        .resp_valid          (resp_valid),
        .resp_ready          (resp_ready),
        .resp_rdata          (resp_rdata),
        .resp_err            (resp_err),
        .ext_reset           (ext_reset),
        .dsid                (dsid),
        .trigger_axis_tvalid (tvalid),
        .trigger_axis_tready (tready),
        .trigger_axis_tdata  (tdata)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    int cyc = 0;
    always @(posedge SYS_CLK) cyc <= cyc + 1;

    // reference model
    logic [DW-1:0] dsid_m [NC];
    logic [NC-1:0] hold_m;
    logic [NC-1:0] lock_m;
    int            pulse_end [NC];
    logic [TW-1:0] q [$];
    int unsigned   ovf_m;
    bit            push_pend, pop_pend, mon_en;
    logic [TW-1:0] push_word;
    int            trmode;
    int            n_checks = 0;
    int            n_pass = 0;
    logic [NC*DW-1:0] pk;
    logic [NC-1:0]    ex;
    logic [TW-1:0]    junk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            dsid_m[c]    = '0;
            pulse_end[c] = 0;
        end
        hold_m = '1;
        lock_m = '0;
        q.delete();
        ovf_m = 0;
        push_pend = 0;
        pop_pend = 0;
    endtask

    // k is the index of the clock edge that accepted the request
    task automatic model_access(input logic wr, input logic [7:0] a, input logic [31:0] wd,
                                input int k, output logic [31:0] d, output logic e);
        int idx;
        d = '0;
        e = 1'b0;
        idx = int'(a);
        if (a < 8'h10) begin
            if (idx >= NC)        e = 1'b1;
            else if (!wr)         d[DW-1:0] = dsid_m[idx];
            else if (lock_m[idx]) e = 1'b1;
            else                  dsid_m[idx] = wd[DW-1:0];
        end else begin
            case (a)
                8'h10: begin
                    for (int c = 0; c < NC; c++) begin
                        if (wr) begin
                            if (wd[c]) pulse_end[c] = k + RC;
                        end else begin
                            d[c] = hold_m[c] | ((k - 1) < pulse_end[c]);
                        end
                    end
                end
                8'h11: if (wr) hold_m = wd[NC-1:0]; else d[NC-1:0] = hold_m;
                8'h12: begin
                    if (wr) begin
                        push_pend = 1;
                        push_word = wd[TW-1:0];
                    end else begin
                        e = 1'b1;
                    end
                end
                8'h13: begin
                    if (wr) begin
                        e = 1'b1;
                    end else begin
                        d = {ovf_m[15:0], 8'h00, 8'(q.size())};
                        ovf_m = 0;
                    end
                end
`ifdef PARD_CP_DSID_LOCK_EN
                8'h14: if (wr) lock_m = lock_m | wd[NC-1:0]; else d[NC-1:0] = lock_m;
`endif
                default: e = 1'b1;
            endcase
        end
    endtask

    // per-cycle: apply last edge's FIFO effects, compare outputs, pick tready
    always @(negedge SYS_CLK) begin
        if (mon_en) begin
            if (pop_pend) junk = q.pop_front();
            if (push_pend) begin
                if (q.size() < DEPTH) q.push_back(push_word);
                else if (ovf_m < 32'hFFFF) ovf_m++;
                push_pend = 0;
            end
            for (int c = 0; c < NC; c++) begin
                ex[c] = hold_m[c] | (cyc < pulse_end[c]);
                pk[c*DW +: DW] = dsid_m[c];
            end
            check("ext_reset", ext_reset, ex);
            check("dsid_bus", dsid, pk);
            check("tvalid", tvalid, q.size() != 0);
            if (q.size() != 0) check("tdata", tdata, q[0]);
            case (trmode)
                0: tready = 1'b0;
                1: tready = 1'b1;
                3: begin tready = 1'b1; trmode = 0; end
                default: tready = 1'($urandom_range(0, 1));
            endcase
            pop_pend = tready && (q.size() != 0);
        end
    end

    // called just after a falling edge; returns at a falling edge
    task automatic do_req(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                          input int unsigned stall, output logic [31:0] rd, output logic er);
        logic [31:0] exp_d;
        logic        exp_e;
        int unsigned n;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge SYS_CLK);
            n++;
        end
        check("req_ready_wait", req_ready, 1'b1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge SYS_CLK);
        #1;
        model_access(wr, addr, wd, cyc, exp_d, exp_e);
        @(negedge SYS_CLK);
        req_valid = 1'b0;
        req_addr  = 8'($urandom);
        req_wdata = $urandom;
        check("resp_valid", resp_valid, 1'b1);
        check("req_ready_busy", req_ready, 1'b0);
        check($sformatf("rdata@%02h", addr), resp_rdata, exp_d);
        check($sformatf("err@%02h", addr), resp_err, exp_e);
        rd = resp_rdata;
        er = resp_err;
        resp_ready = 1'b0;
        repeat (stall) begin
            @(negedge SYS_CLK);
            check("resp_hold_valid", resp_valid, 1'b1);
            check("resp_hold_rdata", resp_rdata, exp_d);
        end
        resp_ready = 1'b1;
        @(negedge SYS_CLK);
        resp_ready = 1'b0;
        check("resp_done", resp_valid, 1'b0);
        check("req_ready_back", req_ready, 1'b1);
    endtask

    logic [7:0] addr_pool [14] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h05, 8'h0F, 8'h10,
                                   8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h20, 8'hFF};

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [7:0]  a;
        RSTN = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        resp_ready = 1'b0;
        tready = 1'b0;
        mon_en = 0;
        trmode = 0;
        model_reset();
        repeat (3) @(negedge SYS_CLK);
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_rdata", resp_rdata, 32'h0);
        check("rst_err", resp_err, 1'b0);
        check("rst_dsid", dsid, '0);
        check("rst_ext_reset", ext_reset, 3'b111);
        check("rst_tvalid", tvalid, 1'b0);
        RSTN = 1'b1;
        @(negedge SYS_CLK);
        mon_en = 1;

        // hold mask
        do_req(1'b0, 8'h11, 32'h0, 0, rd, er);
        check("hold_reset_val", rd, 32'h7);
        do_req(1'b1, 8'h11, 32'h0, 0, rd, er);
        repeat (2) @(negedge SYS_CLK);

        // DSID
        do_req(1'b1, 8'h01, 32'h0000ABCD, 0, rd, er);
        do_req(1'b0, 8'h01, 32'h0, 1, rd, er);
        check("dsid1_read", rd, 32'h0000ABCD);
        check("dsid1_bus", dsid[31:16], 16'hABCD);
        do_req(1'b1, 8'h03, 32'h1234, 0, rd, er);
        check("dsid_bad_core", er, 1'b1);

        // reset pulse and re-pulse
        do_req(1'b1, 8'h10, 32'h2, 0, rd, er);
        repeat (6) @(negedge SYS_CLK);
        do_req(1'b0, 8'h10, 32'h0, 0, rd, er);
        do_req(1'b1, 8'h10, 32'h2, 0, rd, er);
        repeat (20) @(negedge SYS_CLK);

        // overflow while stalled
        trmode = 0;
        for (int i = 0; i < 10; i++) do_req(1'b1, 8'h12, 32'h100 + i, 0, rd, er);
        do_req(1'b0, 8'h13, 32'h0, 0, rd, er);
        check("stat_ovf2", rd[31:16], 16'd2);
        check("stat_lvl8", rd[7:0], 8'd8);
        do_req(1'b0, 8'h13, 32'h0, 0, rd, er);
        check("stat_ovf_cleared", rd[31:16], 16'd0);

        // full FIFO, push coinciding with a pop
        @(posedge SYS_CLK);
        trmode = 3;
        @(negedge SYS_CLK);
        do_req(1'b1, 8'h12, 32'h55, 0, rd, er);
        check("push_pop_err", er, 1'b0);
        do_req(1'b0, 8'h13, 32'h0, 0, rd, er);
        check("push_pop_lvl", rd[7:0], 8'd8);
        check("push_pop_ovf", rd[31:16], 16'd0);
        trmode = 1;
        repeat (12) @(negedge SYS_CLK);
        do_req(1'b0, 8'h13, 32'h0, 0, rd, er);
        check("drained_lvl", rd[7:0], 8'd0);
        do_req(1'b0, 8'h12, 32'h0, 0, rd, er);
        check("push_read_err", er, 1'b1);

`ifdef PARD_CP_DSID_LOCK_EN
        do_req(1'b1, 8'h14, 32'h1, 0, rd, er);
        do_req(1'b1, 8'h00, 32'h5, 0, rd, er);
        check("locked_write_err", er, 1'b1);
        do_req(1'b0, 8'h00, 32'h0, 0, rd, er);
        check("locked_dsid0", rd, 32'h0);
`else
        do_req(1'b0, 8'h14, 32'h0, 0, rd, er);
        check("lock_absent_err", er, 1'b1);
        do_req(1'b1, 8'h00, 32'h5, 0, rd, er);
        check("dsid0_writable", er, 1'b0);
`endif

        // asynchronous reset with a response in flight
        trmode = 0;
        do_req(1'b1, 8'h11, 32'h0, 0, rd, er);
        do_req(1'b1, 8'h10, 32'h7, 0, rd, er);
        do_req(1'b1, 8'h12, 32'hAA, 0, rd, er);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 8'h11;
        @(posedge SYS_CLK);
        #2;
        RSTN = 1'b0;
        #1;
        check("arst_resp_valid", resp_valid, 1'b0);
        check("arst_req_ready", req_ready, 1'b1);
        check("arst_ext_reset", ext_reset, 3'b111);
        check("arst_tvalid", tvalid, 1'b0);
        check("arst_dsid", dsid, '0);
        req_valid = 1'b0;
        mon_en = 0;
        tready = 1'b0;
        model_reset();
        @(negedge SYS_CLK);
        RSTN = 1'b1;
        @(negedge SYS_CLK);
        mon_en = 1;

        // random traffic
        trmode = 2;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                do_req(1'b1, 8'h12, $urandom, $urandom_range(0, 2), rd, er);
            end else begin
                a = addr_pool[$urandom_range(0, 13)];
                do_req(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 2), rd, er);
            end
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(negedge SYS_CLK);
        end
        trmode = 1;
        repeat (DEPTH + 4) @(negedge SYS_CLK);
        do_req(1'b0, 8'h13, 32'h0, 0, rd, er);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
